// File: rtl/cache_arbiter.sv
// Arbitrates the I-cache and D-cache line requests onto one 4-beat burst memory port.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin on contention (default: data wins).
module cache_arbiter #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [LINE_W-1:0]  i_rdata,
  output logic               i_resp,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [LINE_W-1:0]  d_wdata,
  output logic [LINE_W-1:0]  d_rdata,
  output logic               d_resp,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BURST_W-1:0] mem_wdata,
  input  logic [BURST_W-1:0] mem_rdata,
  input  logic               mem_resp
);

  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_W = $clog2(LINE_W / 8);
  localparam int unsigned IDX_W = $clog2(LINE_W);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] I_RD   = 3'd1;
  localparam logic [2:0] D_RD   = 3'd2;
  localparam logic [2:0] D_WR   = 3'd3;
  localparam logic [2:0] I_DONE = 3'd4;
  localparam logic [2:0] D_DONE = 3'd5;

  logic [2:0]        state;
  logic [2:0]        state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  beat_idx;
  logic              d_req;
  logic              grant_i;
  logic              grant_d;
  logic              in_burst;
  logic              last_beat;

  assign d_req     = d_read | d_write;
  assign in_burst  = (state == I_RD) || (state == D_RD) || (state == D_WR);
  assign last_beat = (cnt == CNT_W'(BEATS - 1));
  assign beat_idx  = IDX_W'(cnt) * IDX_W'(BURST_W);

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  logic last_grant;

  // On contention the side that did not win last time is served
  assign grant_i = i_read && (!d_req || (last_grant == SIDE_D));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= SIDE_D;
    end else if (state == IDLE) begin
      if (grant_i) begin
        last_grant <= SIDE_I;
      end else if (grant_d) begin
        last_grant <= SIDE_D;
      end
    end
  end
`else
  assign grant_i = i_read && !d_req;
`endif

  assign grant_d = d_req && !grant_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; a simultaneous read+write from the data side runs as a writeback
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (grant_i) begin
          state_d = I_RD;
        end else if (grant_d) begin
          state_d = d_write ? D_WR : D_RD;
        end
      end
      I_RD:    if (mem_resp && last_beat) state_d = I_DONE;
      D_RD:    if (mem_resp && last_beat) state_d = D_DONE;
      D_WR:    if (mem_resp && last_beat) state_d = D_DONE;
      I_DONE:  state_d = IDLE;
      D_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line buffer, burst address and beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      line_q <= '0;
      cnt    <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (grant_i) begin
        addr_q <= {i_address[ADDR_W-1:OFF_W], OFF_W'(0)};
      end else if (grant_d) begin
        addr_q <= {d_address[ADDR_W-1:OFF_W], OFF_W'(0)};
        if (d_write) begin
          line_q <= d_wdata;
        end
      end
    end else if (in_burst && mem_resp) begin
      cnt <= cnt + CNT_W'(1);
      if (state != D_WR) begin
        line_q[beat_idx +: BURST_W] <= mem_rdata;
      end
    end
  end

  // Strobes decode straight from the state flop so a reset drops them at once
  assign mem_read    = (state == I_RD) || (state == D_RD);
  assign mem_write   = (state == D_WR);
  assign mem_address = addr_q;
  assign mem_wdata   = line_q[beat_idx +: BURST_W];
  assign i_resp      = (state == I_DONE);
  assign d_resp      = (state == D_DONE);
  assign i_rdata     = line_q;
  assign d_rdata     = line_q;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single burst-mode physical memory port between the instruction cache and the data cache of the RV32I core. The block accepts one full-line request at a time from either cache and runs it as a 4-beat memory burst. For reads it assembles the returned beats into a 256-bit line; for writes it slices the dirty line into beats. It sits between the two cache miss controllers and the memory model / L2 interface.

## Interface
Parameters:
- LINE_W, 256, cache line width in bits
- BURST_W, 64, memory beat width in bits; BEATS = LINE_W/BURST_W = 4
- ADDR_W, 32, address width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- i_read  in  1  instruction-cache line read request, level, held until i_resp
- i_address  in  ADDR_W  instruction line address
- i_rdata  out  LINE_W  assembled line, valid while i_resp=1
- i_resp  out  1  one-cycle completion pulse to the instruction cache
- d_read  in  1  data-cache line read request, level
- d_write  in  1  data-cache line writeback request, level
- d_address  in  ADDR_W  data line address
- d_wdata  in  LINE_W  writeback line
- d_rdata  out  LINE_W  assembled line, valid while d_resp=1
- d_resp  out  1  one-cycle completion pulse to the data cache
- mem_read  out  1  burst read strobe, held for the whole burst
- mem_write  out  1  burst write strobe, held for the whole burst
- mem_address  out  ADDR_W  line base, low 5 bits forced to 0
- mem_wdata  out  BURST_W  current write beat
- mem_rdata  in  BURST_W  current read beat
- mem_resp  in  1  one pulse per accepted or returned beat

## Operation
- States: IDLE, I_RD, D_RD, D_WR, I_DONE, D_DONE. Reset state is IDLE.
- IDLE: evaluate the requests (see Configuration).
  - On a grant, latch the address (low 5 bits cleared) into addr_q. For D_WR, also latch d_wdata into line_q.
  - Clear beat counter cnt (2 bits).
  - Go to I_RD, D_RD or D_WR.
- d_read and d_write asserted together: treated as d_write.
- I_RD / D_RD:
  - mem_read=1 and mem_address=addr_q.
  - On each mem_resp, write mem_rdata into line_q[cnt*64 +: 64] and increment cnt.
  - On the mem_resp where cnt==3, go to I_DONE / D_DONE.
- D_WR:
  - mem_write=1 and mem_wdata=line_q[cnt*64 +: 64].
  - Same counting rule; exit to D_DONE.
- I_DONE / D_DONE: assert i_resp or d_resp for exactly one cycle, with i_rdata/d_rdata=line_q, then go to IDLE.
- i_rdata and d_rdata are both driven from line_q at all times. Their contents are only meaningful during the matching resp.
- Requesters drop the request the cycle after resp. The mandatory IDLE cycle therefore never re-grants a completed request.
- Requests arriving mid-burst wait; they are not lost, because they are level-held.
- mem_resp in IDLE or in a DONE state is ignored.
- cnt wraps 3→0 only at burst end.

## Timing
- Reset values: all outputs 0, line_q=0, addr_q=0, cnt=0, state IDLE, last_grant=data.
- Request seen in IDLE at edge N → mem_read or mem_write high from cycle N+1.
- Read latency: i_resp/d_resp is asserted in the cycle after the 4th mem_resp.
- Minimum total latency: 1 (grant) + 4 beats + 1 (resp) = 6 cycles.
- Back-to-back transfers are separated by at least one IDLE cycle after DONE.
- mem_read and mem_write are never high together, and never high in IDLE or DONE.
- rst asserted mid-burst: immediately returns to IDLE and drops mem_read/mem_write (combinational from state). No resp is issued for the aborted transfer.

## Configuration
- ARB_ROUND_ROBIN_EN undefined: fixed priority. When both caches request in IDLE, data wins.
- ARB_ROUND_ROBIN_EN defined:
  - A last_grant flop records the side of the most recent grant.
  - When both caches request in IDLE, the side not in last_grant is granted.
  - last_grant resets to data, so the first contention goes to instruction.
- In both modes, a lone requester is always granted.

## Test plan
- i_read=1, i_address=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → mem_address=0x0000_1220, i_resp one cycle with i_rdata={44..,33..,22..,11..}, 6 cycles after request with zero-wait memory.
- d_write=1, d_address=0x8000_0040, d_wdata=256'hAAAA..._BBBB...CCCC..._DDDD... → mem_wdata sequence D,C,B,A (low beat first), mem_write held 4 beats, then d_resp pulse.
- i_read and d_read raised in the same cycle → default build: D_RD first, then I_RD; ARB_ROUND_ROBIN_EN: I_RD first. In both builds, the second requester completes without being reissued.
- Memory inserting 3 stall cycles between beats → cnt advances only on mem_resp; mem_read stays high throughout; data is correct.
- rst pulsed after beat 2 of a D_RD → mem_read=0 during reset; no d_resp. After reset, the held d_read restarts a full 4-beat burst.
- Stray mem_resp pulse in IDLE → no state change, no resp output.
